// File: rtl/memory_matrix_pkg.sv
// memory_matrix_pkg: shared types and constants for the Memory Matrix game blocks
package memory_matrix_pkg;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  typedef enum logic [1:0] {IDLE, PICK, DONE} bg_state_e;
  function automatic int cells_of(input int rows, input int cols);
    return rows * cols;
  endfunction
  function automatic int idx_w_of(input int cells);
    return $clog2(cells);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with load; a zero load falls back to SEED
module lfsr16
  import memory_matrix_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= SEED;
    else if (load) q <= (load_val == 16'h0) ? SEED : load_val;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/board_gen.sv
// board_gen: places min(num_tiles,CELLS) distinct lit tiles using an LFSR and linear probing.
// Define BOARD_GEN_SEED_EN to add seed_load/seed ports for reproducible boards.
module board_gen
  import memory_matrix_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int CELLS = cells_of(ROWS, COLS),
  localparam int IDX_W = idx_w_of(CELLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       num_tiles,
  output logic             busy,
  output logic             done,
  output logic [CELLS-1:0] board
`ifdef BOARD_GEN_SEED_EN
  ,
  input  logic             seed_load,
  input  logic [15:0]      seed
`endif
);
  bg_state_e state;
  logic [6:0] remaining;
  logic [IDX_W-1:0] probe;
  logic [15:0] lfsr_q;
  logic ld;
  logic [15:0] ld_val;
  logic lfsr_unused;
`ifdef BOARD_GEN_SEED_EN
  assign ld = seed_load;
  assign ld_val = seed;
`else
  assign ld = 1'b0;
  assign ld_val = 16'h0;
`endif
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk), .reset(reset), .en(1'b1), .load(ld), .load_val(ld_val), .q(lfsr_q)
  );
  wire [IDX_W-1:0] cand = lfsr_q[IDX_W-1:0];
  assign lfsr_unused = ^lfsr_q[15:IDX_W];
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      board <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      remaining <= '0;
      probe <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            board <= '0;
            remaining <= (num_tiles > 7'(CELLS)) ? 7'(CELLS) : num_tiles;
            probe <= cand;
            busy <= 1'b1;
            state <= PICK;
          end
        PICK:
          if (remaining == 7'd0) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else if (!board[probe]) begin
            board[probe] <= 1'b1;
            remaining <= remaining - 7'd1;
            probe <= cand;
          end else probe <= probe + IDX_W'(1);
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_board_gen.sv
// tb_board_gen: directed and randomized checks of board_gen against a small placement model
module tb_board_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [6:0] num_tiles = '0;
  logic busy, done;
  logic [15:0] board;
`ifdef BOARD_GEN_SEED_EN
  logic seed_load = 1'b0;
  logic [15:0] seed = '0;
`endif
  int checks = 0;
  int errors = 0;
  logic [15:0] m_lfsr;

  board_gen dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done), .board(board)
`ifdef BOARD_GEN_SEED_EN
    , .seed_load(seed_load), .seed(seed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk)
    if (reset) m_lfsr <= 16'hACE1;
`ifdef BOARD_GEN_SEED_EN
    else if (seed_load) m_lfsr <= (seed == 16'h0) ? 16'hACE1 : seed;
`endif
    else m_lfsr <= nxt(m_lfsr);

  // l0 is the LFSR value seen at the accepting edge; returns the board and the edge at which done rises
  function automatic void model(input logic [15:0] l0, input int n, output logic [15:0] b, output int edges);
    logic [15:0] l;
    logic [3:0] p;
    int rem;
    rem = (n > 16) ? 16 : n;
    p = l0[3:0];
    l = nxt(l0);
    b = '0;
    edges = 0;
    for (int e = 1; e < 1000; e++) begin
      if (rem == 0) begin
        edges = e;
        break;
      end
      if (!b[p]) begin
        b[p] = 1'b1;
        rem--;
        p = l[3:0];
      end else p = p + 4'd1;
      l = nxt(l);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_round(input int n, output logic [15:0] b, output int edges);
    logic [15:0] eb;
    int ee, e;
    @(negedge clk);
    num_tiles = 7'(n);
    start = 1'b1;
    model(m_lfsr, n, eb, ee);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("board_cleared", {16'b0, board}, 32'd0);
    e = 0;
    while (!done && e < 400) begin
      @(negedge clk);
      e++;
    end
    check("done_edge", e, ee);
    check("board", {16'b0, board}, {16'b0, eb});
    check("popcount", $countones(board), (n > 16) ? 16 : n);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    b = board;
    edges = e;
    @(negedge clk);
    check("done_width", {31'b0, done}, 32'd0);
  endtask

  typedef struct {
    int n;
    int pop;
  } vec_t;

  initial begin
    vec_t vecs[8];
    logic [15:0] b, b1, b2, seen;
    int edges;
    bit bad;
    vecs[0] = '{5, 5};
    vecs[1] = '{0, 0};
    vecs[2] = '{16, 16};
    vecs[3] = '{100, 16};
    vecs[4] = '{1, 1};
    vecs[5] = '{15, 15};
    vecs[6] = '{8, 8};
    vecs[7] = '{17, 16};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_board", {16'b0, board}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_round(vecs[i].n, b, edges);
      check("vec_popcount", $countones(b), vecs[i].pop);
      if (vecs[i].n == 0) check("zero_done_edge", edges, 32'd1);
      if (vecs[i].pop == 16) check("full_board", {16'b0, b}, 32'h0000FFFF);
    end

    run_round(5, b, edges);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (board !== b || done) bad = 1'b1;
    end
    check("board_stable", {31'b0, bad}, 32'd0);

    @(negedge clk);
    num_tiles = 7'd8;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    check("second_start_ignored", $countones(board), 32'd1);
    check("busy_mid_pick", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_board", {16'b0, board}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) bad = 1'b1;
      @(negedge clk);
    end
    check("midreset_no_done", {31'b0, bad}, 32'd0);
    run_round(8, b, edges);

`ifdef BOARD_GEN_SEED_EN
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      seed = 16'h1234;
      seed_load = 1'b1;
      @(negedge clk);
      seed_load = 1'b0;
      repeat (2) @(negedge clk);
      run_round(6, b, edges);
      if (r == 0) b1 = b;
    end
    check("seed_repeat", {16'b0, b}, {16'b0, b1});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_round(6, b1, edges);
    @(negedge clk);
    seed = 16'h0;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (2) @(negedge clk);
    run_round(6, b2, edges);
    check("seed_zero_default", {16'b0, b2}, {16'b0, b1});
`endif

    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_round(int'($urandom_range(0, 20)), b, edges);
      seen |= b;
    end
    check("all_cells_lit", {16'b0, seen}, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
